// File: rtl/serial_compare_frame_ctrl_if.sv
// serial_compare_frame_ctrl_if
//   Bundles the signals of serial_compare_frame_ctrl other than clk/rst.
//   The signals fall into three groups:
//     operand port : in_valid, in_ready, in_a, in_b
//     comparator   : cmp_rst, ser_a, ser_b, ser_valid, cmp_lt, cmp_eq, cmp_gt
//     result port  : out_valid, out_ready, out_lt, out_eq, out_gt, mismatch
//   slave  : the framing controller's view of the bundle.
//   master : the view of whatever surrounds it (operand source, comparator,
//            result sink).
interface serial_compare_frame_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             cmp_rst;
  logic             ser_a;
  logic             ser_b;
  logic             ser_valid;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             cmp_gt;

  logic             out_valid;
  logic             out_ready;
  logic             out_lt;
  logic             out_eq;
  logic             out_gt;
  logic             mismatch;

  modport slave (
    input  in_valid, in_a, in_b, cmp_lt, cmp_eq, cmp_gt, out_ready,
    output in_ready, cmp_rst, ser_a, ser_b, ser_valid,
           out_valid, out_lt, out_eq, out_gt, mismatch
  );

  modport master (
    output in_valid, in_a, in_b, cmp_lt, cmp_eq, cmp_gt, out_ready,
    input  in_ready, cmp_rst, ser_a, ser_b, ser_valid,
           out_valid, out_lt, out_eq, out_gt, mismatch
  );
endinterface

// File: rtl/serial_compare_frame_ctrl.sv
// serial_compare_frame_ctrl
//   Word-framing controller for an MSB-first serial comparator. It takes a
//   WIDTH-bit operand pair over a valid/ready handshake and clears the
//   comparator. It then shifts both operands out MSB-first, waits one drain
//   cycle, and captures the comparator flags. The captured result is held on
//   a valid/ready output port. Only one word pair is in flight at a time.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active high
//   bus  : serial_compare_frame_ctrl_if.slave
//          in_valid/in_ready/in_a/in_b    operand handshake
//          cmp_rst/ser_a/ser_b/ser_valid  drive to the serial comparator
//          cmp_lt/cmp_eq/cmp_gt           flags from the serial comparator
//          out_valid/out_ready            result handshake
//          out_lt/out_eq/out_gt           registered result
//          mismatch                       sticky self-check error
//
// Build option:
//   SERIAL_CMP_SELF_CHECK_EN
//     When defined, a parallel unsigned compare of each accepted pair is
//     latched. It is checked against the captured flags on entry to RESULT.
//     When not defined, mismatch is tied low and no checker is built.
//
// States:
//   state  | meaning
//   IDLE   | in_ready high, waiting for an operand pair
//   CLEAR  | comparator held in reset for one cycle, bit counter loaded
//   SHIFT  | WIDTH cycles of MSB-first data on ser_a/ser_b
//   DRAIN  | equal zero bits presented; flags captured on exit
//   RESULT | out_valid high until out_ready
module serial_compare_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  serial_compare_frame_ctrl_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             res_lt;
  logic             res_eq;
  logic             res_gt;

  logic             accept;
  logic             in_ready_d;
  logic             clear_d;
  logic             ser_valid_d;
  logic             out_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_d  = 1'b0;
    clear_d     = 1'b0;
    ser_valid_d = 1'b0;
    out_valid_d = 1'b0;
    case (state)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        clear_d   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_valid_d = 1'b1;
        if (bit_cnt == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = RESULT;
      end
      RESULT: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = bus.in_valid & (state == IDLE);

  // Operand shift registers and bit counter. The counter is loaded in CLEAR,
  // so a word aborted by reset leaves nothing that affects the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sa <= bus.in_a;
            sb <= bus.in_b;
          end
        end
        CLEAR: begin
          bit_cnt <= CW'(WIDTH - 1);
        end
        SHIFT: begin
          sa      <= {sa[WIDTH-2:0], 1'b0};
          sb      <= {sb[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // By the end of DRAIN the comparator has consumed the LSB, so its flags
  // hold the final decision. The flags stay in these registers until the
  // next capture; reset brings them back to "equal".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_lt <= 1'b0;
      res_eq <= 1'b1;
      res_gt <= 1'b0;
    end else if (state == DRAIN) begin
      res_lt <= bus.cmp_lt;
      res_eq <= bus.cmp_eq;
      res_gt <= bus.cmp_gt;
    end
  end

  // The data bits are gated with the SHIFT decode. In CLEAR and DRAIN the
  // comparator therefore sees equal zero bits, although sa/sb still hold data.
  assign bus.in_ready  = in_ready_d;
  assign bus.ser_valid = ser_valid_d;
  assign bus.ser_a     = ser_valid_d & sa[WIDTH-1];
  assign bus.ser_b     = ser_valid_d & sb[WIDTH-1];
  assign bus.cmp_rst   = rst | clear_d;
  assign bus.out_valid = out_valid_d;
  assign bus.out_lt    = res_lt;
  assign bus.out_eq    = res_eq;
  assign bus.out_gt    = res_gt;

`ifdef SERIAL_CMP_SELF_CHECK_EN
  logic exp_lt;
  logic exp_eq;
  logic exp_gt;
  logic mismatch_r;
  logic flags_onehot;

  assign flags_onehot = ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b100) |
                        ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b010) |
                        ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} == 3'b001);

  // The check uses the same flags that are being captured on the
  // DRAIN->RESULT edge. mismatch is therefore already valid in the first
  // RESULT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_lt     <= 1'b0;
      exp_eq     <= 1'b1;
      exp_gt     <= 1'b0;
      mismatch_r <= 1'b0;
    end else begin
      if (accept) begin
        exp_lt <= (bus.in_a <  bus.in_b);
        exp_eq <= (bus.in_a == bus.in_b);
        exp_gt <= (bus.in_a >  bus.in_b);
      end
      if (state == DRAIN) begin
        if (!flags_onehot ||
            ({bus.cmp_lt, bus.cmp_eq, bus.cmp_gt} != {exp_lt, exp_eq, exp_gt}))
          mismatch_r <= 1'b1;
      end
    end
  end

  assign bus.mismatch = mismatch_r;
`else
  assign bus.mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_serial_compare_frame_ctrl.sv
module tb_serial_compare_frame_ctrl;
  localparam int WIDTH = 8;

  typedef logic [2:0] res_t;   // {lt, eq, gt}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_compare_frame_ctrl_if #(.WIDTH(WIDTH)) bus ();
  serial_compare_frame_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int last_hs = 0;

  res_t       res_q[$];
  logic [1:0] bit_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural MSB-first serial comparator. The first differing bit decides
  // the result; cmp_rst returns it to "equal".
  logic m_lt, m_eq, m_gt;
  logic force_gt = 1'b0;
  always @(posedge clk) begin
    if (bus.cmp_rst) begin
      m_lt <= 1'b0; m_eq <= 1'b1; m_gt <= 1'b0;
    end else if (m_eq && (bus.ser_a != bus.ser_b)) begin
      m_gt <= bus.ser_a; m_lt <= bus.ser_b; m_eq <= 1'b0;
    end
  end
  assign bus.cmp_lt = m_lt;
  assign bus.cmp_eq = m_eq;
  assign bus.cmp_gt = m_gt | force_gt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec, err + 1);
    $fatal(1, "watchdog");
  end

  // Runs one word end to end and checks the CLEAR cycle, the serial bit
  // stream, the result latency and the result value. When hold is nonzero,
  // it also checks that the result is held under backpressure. When b2b is
  // set, it raises in_valid with the next operands in the RESULT cycle.
  task automatic run_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int hold, input bit b2b,
                          input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                          input bit force_bad);
    int   n;
    int   nbits;
    res_t exp;
    res_t got;
    logic [1:0] eb;
    bit_q.delete();
    bus.out_ready = (hold == 0);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    last_hs = cyc;
    bus.in_valid = 1'b0;
    res_q.push_back({a < b, a == b, a > b} | (force_bad ? 3'b001 : 3'b000));
    for (int i = WIDTH - 1; i >= 0; i--) bit_q.push_back({a[i], b[i]});
    vec++;
    if (bus.cmp_rst !== 1'b1 || bus.ser_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      err++;
      $display("FAIL clear_cycle: cmp_rst=%b ser_valid=%b in_ready=%b, required 1 0 0",
               bus.cmp_rst, bus.ser_valid, bus.in_ready);
    end
    n = 0; nbits = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (bus.ser_valid === 1'b1) begin
        eb = (bit_q.size() > 0) ? bit_q.pop_front() : 2'bxx;
        vec++;
        if ({bus.ser_a, bus.ser_b} !== eb) begin
          err++;
          $display("FAIL ser_bit[%0d]: ser_a/ser_b=%b%b, required %b", nbits, bus.ser_a, bus.ser_b, eb);
        end
        nbits++;
      end
    end
    vec++;
    if (n !== WIDTH + 2) begin
      err++;
      $display("FAIL result_latency: out_valid after %0d cycles, required %0d", n, WIDTH + 2);
    end
    vec++;
    if (nbits !== WIDTH) begin
      err++;
      $display("FAIL ser_count: %0d ser_valid cycles, required %0d", nbits, WIDTH);
    end
    exp = (res_q.size() > 0) ? res_q.pop_front() : 3'bxxx;
    got = {bus.out_lt, bus.out_eq, bus.out_gt};
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL result a=%h b=%h: lt/eq/gt=%b, required %b", a, b, got, exp);
    end
    vec++;
    if (bus.mismatch !== force_bad) begin
      err++;
      $display("FAIL mismatch_flag: mismatch=%b, required %b", bus.mismatch, force_bad);
    end
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1; bus.in_a = ~a; bus.in_b = a;
      @(negedge clk);
      vec++;
      if (bus.out_valid !== 1'b1 || {bus.out_lt, bus.out_eq, bus.out_gt} !== exp || bus.in_ready !== 1'b0) begin
        err++;
        $display("FAIL hold[%0d]: out_valid=%b flags=%b in_ready=%b, required 1 %b 0",
                 k, bus.out_valid, {bus.out_lt, bus.out_eq, bus.out_gt}, exp, bus.in_ready);
      end
    end
    bus.in_valid  = b2b;
    bus.in_a      = na;
    bus.in_b      = nb;
    bus.out_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || {bus.out_lt, bus.out_eq, bus.out_gt} !== exp) begin
      err++;
      $display("FAIL return_idle: in_ready=%b out_valid=%b flags=%b, required 1 0 %b",
               bus.in_ready, bus.out_valid, {bus.out_lt, bus.out_eq, bus.out_gt}, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vec++;
    if (bus.cmp_rst !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.ser_valid !== 1'b0 || {bus.out_lt, bus.out_eq, bus.out_gt} !== 3'b010 || bus.mismatch !== 1'b0) begin
      err++;
      $display("FAIL reset_state: cmp_rst=%b in_ready=%b out_valid=%b ser_valid=%b flags=%b mismatch=%b, required 1 1 0 0 010 0",
               bus.cmp_rst, bus.in_ready, bus.out_valid, bus.ser_valid,
               {bus.out_lt, bus.out_eq, bus.out_gt}, bus.mismatch);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.cmp_rst !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      err++;
      $display("FAIL post_reset_idle: cmp_rst=%b in_ready=%b out_valid=%b, required 0 1 0",
               bus.cmp_rst, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_equal;
    run_word(8'h5A, 8'h5A, 0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_msb_lsb;
    run_word(8'h80, 8'h7F, 0, 1'b0, '0, '0, 1'b0);
    run_word(8'h01, 8'h02, 0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_word(WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)), 0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_word(8'h3C, 8'hC3, 20, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    vec++;
    if (bus.in_ready !== 1'b1 || bus.cmp_rst !== 1'b0) begin
      err++;
      $display("FAIL stays_idle: in_ready=%b cmp_rst=%b, required 1 0", bus.in_ready, bus.cmp_rst);
    end
  endtask

  task automatic test_back_to_back;
    int t1;
    run_word(8'h33, 8'h34, 0, 1'b1, 8'hC0, 8'h0C, 1'b0);
    t1 = last_hs;
    run_word(8'hC0, 8'h0C, 0, 1'b0, '0, '0, 1'b0);
    vec++;
    if (last_hs - t1 !== WIDTH + 4) begin
      err++;
      $display("FAIL word_period: %0d cycles between handshakes, required %0d", last_hs - t1, WIDTH + 4);
    end
  endtask

  task automatic test_reset_mid_shift;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 8'hFF; bus.in_b = 8'h00;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (bus.ser_valid !== 1'b1) begin
      err++;
      $display("FAIL pre_abort_shift: ser_valid=%b, required 1", bus.ser_valid);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (bus.ser_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.cmp_rst !== 1'b1) begin
      err++;
      $display("FAIL abort_shift: ser_valid=%b in_ready=%b out_valid=%b cmp_rst=%b, required 0 1 0 1",
               bus.ser_valid, bus.in_ready, bus.out_valid, bus.cmp_rst);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec++;
    if ({bus.out_lt, bus.out_eq, bus.out_gt} !== 3'b010 || bus.cmp_rst !== 1'b0) begin
      err++;
      $display("FAIL abort_flags: flags=%b cmp_rst=%b, required 010 0",
               {bus.out_lt, bus.out_eq, bus.out_gt}, bus.cmp_rst);
    end
    @(negedge clk);
    run_word(8'h00, 8'hFF, 0, 1'b0, '0, '0, 1'b0);
  endtask

`ifdef SERIAL_CMP_SELF_CHECK_EN
  task automatic test_self_check;
    force_gt = 1'b1;
    run_word(8'h01, 8'h02, 0, 1'b0, '0, '0, 1'b1);
    force_gt = 1'b0;
    run_word(8'h10, 8'h10, 0, 1'b0, '0, '0, 1'b1);
    #2 rst = 1'b1;
    #1;
    vec++;
    if (bus.mismatch !== 1'b0) begin
      err++;
      $display("FAIL mismatch_clear: mismatch=%b, required 0", bus.mismatch);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_equal();
    test_msb_lsb();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef SERIAL_CMP_SELF_CHECK_EN
    test_self_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/serial_compare_frame_ctrl.md
# serial_compare_frame_ctrl

Word-framing controller wrapped around the MSB-first serial comparator FSM. Accepts a pair of parallel WIDTH-bit operands over a valid/ready handshake, clears the comparator, shifts both operands out MSB-first on ser_a/ser_b, then samples the comparator's three flags and holds the result on a valid/ready output port. One word pair is in flight at a time.

## Interface

- WIDTH, default 8: operand width in bits, at least 2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  operand A, sampled only on in_valid & in_ready.
- in_b  in  WIDTH  operand B, sampled only on in_valid & in_ready.
- cmp_rst  out  1  clear to comparator; high in CLEAR and whenever rst is high.
- ser_a  out  1  serial A bit to comparator.
- ser_b  out  1  serial B bit to comparator.
- ser_valid  out  1  high while a data bit is on ser_a/ser_b.
- cmp_lt / cmp_eq / cmp_gt  in  1 each  comparator flags a_less_b / a_eq_b / a_greater_b.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_lt / out_eq / out_gt  out  1 each  registered result, exactly one high when out_valid.
- mismatch  out  1  sticky self-check error; see Configuration.

## Operation

- States: IDLE, CLEAR, SHIFT, DRAIN, RESULT. Reset state IDLE.
- IDLE: in_ready=1. On in_valid & in_ready, latch in_a/in_b into shift registers sa/sb and go to CLEAR.
- CLEAR: one cycle. cmp_rst=1, ser_a=ser_b=0, ser_valid=0. Go to SHIFT. Bit counter loaded with WIDTH-1.
- SHIFT: WIDTH cycles. ser_a=sa[WIDTH-1], ser_b=sb[WIDTH-1], ser_valid=1. Each cycle sa/sb shift left by one with zero fill, counter decrements. Counter 0 -> DRAIN.
- DRAIN: one cycle. ser_a=ser_b=0 (equal bits, so comparator flags reflect the accumulated state only). On the clock edge leaving DRAIN, capture cmp_lt/eq/gt into out_lt/eq/gt. Go to RESULT.
- RESULT: out_valid=1; results held stable. On out_valid & out_ready go to IDLE.
- Outside RESULT: out_valid=0; out_lt/eq/gt retain the last captured value.
- in_valid is ignored outside IDLE. in_ready is a pure decode of state == IDLE.
- Reset mid-operation: word discarded, state -> IDLE, out_valid and ser_valid drop immediately, cmp_rst high while rst high.

## Timing

- Reset values: in_ready=1 (IDLE), cmp_rst=1 while rst high then 0, ser_a=ser_b=ser_valid=0, out_valid=0, out_lt=out_gt=0, out_eq=1, mismatch=0.
- Handshake at edge t0 gives CLEAR in cycle t0+1 and SHIFT in cycles t0+2 .. t0+WIDTH+1, with the MSB first. DRAIN is in cycle t0+WIDTH+2 and out_valid=1 from cycle t0+WIDTH+3.
- Minimum period per word: WIDTH+4 cycles, with out_ready held high and in_valid high again in the returning IDLE cycle.
- A back-to-back in_valid in the same cycle as the output handshake is not accepted. Acceptance needs the IDLE cycle.
- All outputs except cmp_rst are registered or pure state decodes. No combinational path exists from in_valid or out_ready to any output.

## Configuration

- SERIAL_CMP_SELF_CHECK_EN defined: on input handshake, a parallel compare of in_a vs in_b (unsigned) is latched. On entry to RESULT, if the captured flags differ from it, or are not one-hot, mismatch sets. It stays set until rst.
- Not defined: no parallel comparator or latch is built, and mismatch is tied 0.

## Test plan

- Reset then idle: assert rst mid-cycle, release -> in_ready=1, out_valid=0, out_eq=1, cmp_rst=1 only during rst.
- WIDTH=8, in_a=0x5A, in_b=0x5A, out_ready=1 -> ser_a sequence 0,1,0,1,1,0,1,0 across 8 ser_valid cycles; out_valid at t0+11 with out_eq=1.
- in_a=0x80, in_b=0x7F -> out_gt=1. in_a=0x01, in_b=0x02 -> out_lt=1. Covers MSB decision and LSB decision.
- Backpressure: hold out_ready=0 for 20 cycles after result -> out_valid and flags stable, in_ready=0, new in_valid ignored. Release -> one handshake, IDLE next cycle.
- Reset during SHIFT at bit 3 -> ser_valid=0 and state IDLE immediately. The next pair 0x00 vs 0xFF produces out_lt=1 with no residue from the aborted word.
- With SERIAL_CMP_SELF_CHECK_EN, force cmp_gt=1 on the 0x01 vs 0x02 word -> mismatch=1 from RESULT entry, held until rst.
